// File: rtl/pd_velocity_controller.sv
// -----------------------------------------------------------------------------
// pd_velocity_controller
//
// Sampled fixed-point PD velocity loop driving a sign/magnitude PWM output.
// Every SAMPLE_DIV enabled cycles the controller captures target/current
// velocity and the Kp/Kd gains. It computes
//   u = (Kp*err + Kd*(err - prev_err)) >>> GAIN_SHIFT
// and loads |u| (clipped to 1023) and sign(u) into a shadow register. The
// shadow value is applied at the next PWM counter wrap, so every PWM period
// is whole.
//
// Optional feature macro: PD_DEADBAND_EN. When it is defined, any error with
// |err| <= DEADBAND is treated as zero.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   enable       run control; low clears the controller like reset
//   target_vel   [9:0] unsigned commanded velocity
//   current_vel  [9:0] unsigned measured velocity
//   Kp, Kd       [3:0] unsigned gains from the fuzzy tuner
//   pwm_out      registered PWM drive
//   dir          0 = forward, 1 = reverse (applied register)
//   duty         [9:0] applied duty (applied register)
//   duty_valid   one-cycle pulse when a new duty has been computed
// -----------------------------------------------------------------------------
module pd_velocity_controller #(
    parameter int SAMPLE_DIV = 1024,
    parameter int GAIN_SHIFT = 2,
    parameter int DEADBAND   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] target_vel,
    input  logic [9:0] current_vel,
    input  logic [3:0] Kp,
    input  logic [3:0] Kd,
    output logic       pwm_out,
    output logic       dir,
    output logic [9:0] duty,
    output logic       duty_valid
);

    localparam int               CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [9:0]       DUTY_MAX = 10'd1023;

    // Elaboration-time hook: this block only exists for illegal parameter values.
    if (SAMPLE_DIV < 8 || GAIN_SHIFT < 0 || DEADBAND < 0) begin : g_illegal_params
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_MULT,
        S_SAT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   smp_cnt_q;
    logic [9:0]         pwm_cnt_q;
    logic [3:0]         kp_q, kd_q;
    logic signed [10:0] err_q, prev_err_q;
    logic signed [11:0] derr_q;
    logic signed [14:0] p_q;
    logic signed [15:0] d_q;
    logic [9:0]         shadow_duty_q, duty_q;
    logic               shadow_dir_q, dir_q;
    logic               pwm_q, duty_valid_q;

    logic               clear, tick, wrap, load;
    logic signed [10:0] err_raw, err_cap;
    logic signed [11:0] derr_c;
    logic signed [14:0] p_c;
    logic signed [15:0] d_c;
    logic signed [16:0] sum_c, u_c;
    logic [16:0]        u_abs;
    logic [9:0]         mag_c;
    logic               dir_c;

    // Dropping enable clears everything exactly like reset.
    assign clear = reset | ~enable;
    assign tick  = (smp_cnt_q == CNT_MAX);
    assign wrap  = (pwm_cnt_q == DUTY_MAX);
    assign load  = (state_q == S_SAT);

    always_comb begin
        // NOTE: give every always_comb output a default first; a path that
        // leaves it unassigned would infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (tick) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_MULT;
            S_MULT:    state_d = S_SAT;
            S_SAT:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

`ifdef PD_DEADBAND_EN
    localparam logic [10:0] DB_TH = 11'(DEADBAND);
    logic [10:0] err_abs;
`endif

    always_comb begin
        err_raw = $signed({1'b0, target_vel}) - $signed({1'b0, current_vel});
`ifdef PD_DEADBAND_EN
        err_abs = err_raw[10] ? unsigned'(-err_raw) : unsigned'(err_raw);
        err_cap = (err_abs <= DB_TH) ? '0 : err_raw;
`else
        err_cap = err_raw;
`endif
        derr_c = $signed({err_cap[10], err_cap}) - $signed({prev_err_q[10], prev_err_q});

        // Gains are unsigned, so they are zero-extended before the signed multiply.
        p_c = $signed({11'b0, kp_q}) * $signed({{4{err_q[10]}}, err_q});
        d_c = $signed({12'b0, kd_q}) * $signed({{4{derr_q[11]}}, derr_q});

        sum_c = $signed({{2{p_q[14]}}, p_q}) + $signed({d_q[15], d_q});
        u_c   = sum_c >>> GAIN_SHIFT;   // arithmetic shift rounds toward -inf
        dir_c = u_c[16];
        u_abs = u_c[16] ? unsigned'(-u_c) : unsigned'(u_c);
        mag_c = (u_abs > 17'd1023) ? DUTY_MAX : u_abs[9:0];
    end

    // NOTE: sequential state is only ever assigned with non-blocking (<=), so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= S_IDLE;
            smp_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            kp_q          <= '0;
            kd_q          <= '0;
            err_q         <= '0;
            prev_err_q    <= '0;
            derr_q        <= '0;
            p_q           <= '0;
            d_q           <= '0;
            shadow_duty_q <= '0;
            shadow_dir_q  <= 1'b0;
            duty_q        <= '0;
            dir_q         <= 1'b0;
            pwm_q         <= 1'b0;
            duty_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            smp_cnt_q    <= tick ? '0 : smp_cnt_q + CNT_W'(1);
            pwm_cnt_q    <= pwm_cnt_q + 10'd1;   // free-running 0..1023
            pwm_q        <= (pwm_cnt_q < duty_q);
            duty_valid_q <= load;

            if (state_q == S_CAPTURE) begin
                kp_q       <= Kp;
                kd_q       <= Kd;
                err_q      <= err_cap;
                derr_q     <= derr_c;
                prev_err_q <= err_cap;
            end

            if (state_q == S_MULT) begin
                p_q <= p_c;
                d_q <= d_c;
            end

            if (load) begin
                shadow_duty_q <= mag_c;
                shadow_dir_q  <= dir_c;
            end

            // Apply at the period boundary only; a result finishing on the
            // wrap cycle itself bypasses the shadow so it is not a period late.
            if (wrap) begin
                duty_q <= load ? mag_c : shadow_duty_q;
                dir_q  <= load ? dir_c : shadow_dir_q;
            end
        end
    end

    assign pwm_out    = pwm_q;
    assign dir        = dir_q;
    assign duty       = duty_q;
    assign duty_valid = duty_valid_q;

endmodule

// File: tb/tb_pd_velocity_controller.sv
// -----------------------------------------------------------------------------
// Testbench for pd_velocity_controller (default parameters).
// The stimulus process drives one input set per sample period and pushes the
// expected result onto a scoreboard queue. A negedge monitor pops an entry on
// each duty_valid pulse and checks the following:
//   - the pulse timing;
//   - the duty/dir applied after the next PWM wrap;
//   - the number of pwm_out high cycles over that whole period;
//   - the all-zero outputs after reset or disable.
// -----------------------------------------------------------------------------
module tb_pd_velocity_controller;

    localparam int SAMPLE_DIV = 1024;
    localparam int GAIN_SHIFT = 2;
    localparam int DEADBAND   = 4;

    logic       clk, reset, enable;
    logic [9:0] target_vel, current_vel;
    logic [3:0] Kp, Kd;
    logic       pwm_out, dir, duty_valid;
    logic [9:0] duty;

    pd_velocity_controller #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .GAIN_SHIFT(GAIN_SHIFT),
        .DEADBAND  (DEADBAND)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .target_vel (target_vel),
        .current_vel(current_vel),
        .Kp         (Kp),
        .Kd         (Kd),
        .pwm_out    (pwm_out),
        .dir        (dir),
        .duty       (duty),
        .duty_valid (duty_valid)
    );

    typedef struct {
        int duty;
        int dir;
        int dv_cyc;   // monitor cycle at which duty_valid must be seen
        int due;      // monitor cycle at which the new duty must be applied
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   prev_m = 0;
    bit   done   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the PD law with plain integer arithmetic.
    // ------------------------------------------------------------------
    task automatic issue(input int t, input int c, input int kp, input int kd, input int lead);
        exp_t e;
        int   err, derr, sum, div, u;
        target_vel  = 10'(t);
        current_vel = 10'(c);
        Kp          = 4'(kp);
        Kd          = 4'(kd);
        err = t - c;
`ifdef PD_DEADBAND_EN
        if (((err < 0) ? -err : err) <= DEADBAND) err = 0;
`endif
        derr   = err - prev_m;
        prev_m = err;
        sum    = kp * err + kd * derr;
        div    = 1 << GAIN_SHIFT;
        u      = (sum >= 0) ? sum / div : -((-sum + div - 1) / div);
        e.dir  = (u < 0) ? 1 : 0;
        e.duty = (u < 0) ? -u : u;
        if (e.duty > 1023) e.duty = 1023;
        e.dv_cyc = cyc + lead;
        e.due    = 0;
        exp_q.push_back(e);
    endtask

    // Release reset/enable. The counters start at zero on the next edge.
    // The first capture happens 1025 edges later.
    task automatic begin_phase(input int t, input int c, input int kp, input int kd);
        @(posedge clk); #2;
        reset  = 1'b0;
        enable = 1'b1;
        prev_m = 0;
        issue(t, c, kp, kd, 1028);
        repeat (1030) @(posedge clk);
        #2;
    endtask

    // Called a few cycles after a capture. The next capture is 1019 edges away.
    task automatic next_sample(input int t, input int c, input int kp, input int kd);
        issue(t, c, kp, kd, 1022);
        repeat (1024) @(posedge clk);
        #2;
    endtask

    task automatic rand_sample();
        int t, c;
        t = int'($urandom_range(1023));
        if ($urandom_range(3) == 0) begin
            c = t + int'($urandom_range(12)) - 6;
            if (c < 0) c = 0;
            if (c > 1023) c = 1023;
        end else begin
            c = int'($urandom_range(1023));
        end
        next_sample(t, c, int'($urandom_range(15)), int'($urandom_range(15)));
    endtask

    // Start a sample, then kill it with reset or enable while it is in MULT.
    task automatic abort_at_mult(input int t, input int c, input int kp, input int kd, input bit by_reset);
        issue(t, c, kp, kd, 1022);
        repeat (1019) @(posedge clk);
        #2;
        if (by_reset) reset = 1'b1;
        else          enable = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        target_vel  = '0;
        current_vel = '0;
        Kp          = '0;
        Kd          = '0;
        repeat (5) @(posedge clk);

        begin_phase(50, 11, 3, 2);      // derr = err = 39 -> 48
        next_sample(50, 11, 3, 2);      // derr = 0 -> 29
        next_sample(11, 50, 3, 0);      // u = -30 -> reverse
        next_sample(1023, 0, 15, 15);   // saturates at 1023
        next_sample(53, 50, 15, 0);     // inside deadband when enabled
        next_sample(55, 50, 15, 0);     // (15*5)>>2 = 18
        for (int i = 0; i < 10; i++) rand_sample();
        abort_at_mult(50, 11, 3, 0, 1'b1);

        begin_phase(50, 11, 3, 0);      // 29
        next_sample(50, 11, 3, 2);      // derr = 0 -> 29
        for (int i = 0; i < 4; i++) rand_sample();
        abort_at_mult(200, 10, 7, 9, 1'b0);

        begin_phase(50, 11, 3, 2);      // prev_err cleared again -> 48
        for (int i = 0; i < 4; i++) rand_sample();
        // Hold the last inputs so the final results reach a full PWM period.
        next_sample(int'(target_vel), int'(current_vel), int'(Kp), int'(Kd));
        next_sample(int'(target_vel), int'(current_vel), int'(Kp), int'(Kd));

        done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    exp_t e_cur, e_pend;
    bit   clr_prev     = 1'b0;
    bit   win_active   = 1'b0;
    bit   done_checked = 1'b0;
    int   win_cnt      = 0;
    int   win_left     = 0;
    int   win_exp      = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (clr_prev) begin
            check("clear_pwm_out", pwm_out, 0);
            check("clear_duty", duty, 0);
            check("clear_dir", dir, 0);
            check("clear_duty_valid", duty_valid, 0);
        end
        if (reset || !enable) begin
            exp_q.delete();
            pend_q.delete();
            win_active = 1'b0;
            clr_prev   = 1'b1;
        end else begin
            clr_prev = 1'b0;
            if (win_active) begin
                win_cnt  = win_cnt + (pwm_out ? 1 : 0);
                win_left = win_left - 1;
                if (win_left == 0) begin
                    check("pwm_high_cycles", win_cnt, win_exp);
                    win_active = 1'b0;
                end
            end
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                e_pend = pend_q.pop_front();
                check("duty_applied", duty, e_pend.duty);
                check("dir_applied", dir, e_pend.dir);
                win_active = 1'b1;
                win_cnt    = pwm_out ? 1 : 0;
                win_left   = 1023;
                win_exp    = e_pend.duty;
            end
            if (duty_valid) begin
                check("duty_valid_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e_cur = exp_q.pop_front();
                    check("duty_valid_latency", cyc, e_cur.dv_cyc);
                    e_cur.due = cyc + 1022;
                    pend_q.push_back(e_cur);
                end
            end
            if (done && !done_checked) begin
                check("samples_outstanding", exp_q.size(), 0);
                done_checked = 1'b1;
            end
        end
    end

endmodule
